flow_ctrl_unit: RTL and testbench

Program-flow controller that consumes the ALU's zero/carry/sign flags and executes the program-flow class of operations: trap, no-op, jump unconditional, jump zero, jump sign, jump zero-sign, load status register and XOR status register. It owns the 20-bit program counter, the status register and trap state. It sits between instruction decode (op handshake) and fetch (pc/flush), on the receiving end of the ALU flag outputs.

---
 rtl/flow_ctrl_unit.sv | 137 +++++++++++++
 tb/tb_flow_ctrl_unit.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flow_ctrl_unit.sv
// flow_ctrl_unit: program counter, status register and trap sequencing for flow-class ops.
// Optional macro FLOW_FLAG_BYPASS_EN lets conditional jumps see same-cycle ALU flags.
module flow_ctrl_unit #(
   parameter logic [19:0] RESET_PC    = 20'h00000,
   parameter logic [19:0] TRAP_VECTOR = 20'hFFF00
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        op_valid,
   output logic        op_ready,
   input  logic [2:0]  op_code,
   input  logic [19:0] op_target,
   input  logic [2:0]  op_sr_imm,
   input  logic        alu_flag_valid,
   input  logic        alu_zero,
   input  logic        alu_carry,
   input  logic        alu_sign,
   input  logic        trap_clear,
   output logic [19:0] pc,
   output logic [3:0]  sr,
   output logic [19:0] epc,
   output logic        flush,
   output logic        trapped,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_FLUSH = 2'd1,
      ST_TRAP  = 2'd2
   } state_t;

   localparam logic [2:0] OP_TRAP = 3'd0;
   localparam logic [2:0] OP_NOP  = 3'd1;
   localparam logic [2:0] OP_JMP  = 3'd2;
   localparam logic [2:0] OP_JZ   = 3'd3;
   localparam logic [2:0] OP_JS   = 3'd4;
   localparam logic [2:0] OP_JZS  = 3'd5;
   localparam logic [2:0] OP_LSR  = 3'd6;
   localparam logic [2:0] OP_XSR  = 3'd7;

   state_t      state;
   logic        accept;
   logic        cond_zero;
   logic        cond_sign;
   logic        jump_taken;
   logic [19:0] pc_inc;

   // Handshake: an op transfers on the rising edge where op_valid && op_ready;
   // op_ready never depends on op_valid and is low throughout FLUSH, TRAP and reset.
   assign op_ready  = (state == ST_RUN) && !rst;
   assign accept    = op_valid && op_ready;
   assign pc_inc    = pc + 20'd1;
   assign dbg_state = state;

`ifdef FLOW_FLAG_BYPASS_EN
   assign cond_zero = alu_flag_valid ? alu_zero : sr[0];
   assign cond_sign = alu_flag_valid ? alu_sign : sr[2];
`else
   assign cond_zero = sr[0];
   assign cond_sign = sr[2];
`endif

   always_comb begin
      jump_taken = 1'b0;
      case (op_code)
         OP_JMP:  jump_taken = 1'b1;
         OP_JZ:   jump_taken = cond_zero;
         OP_JS:   jump_taken = cond_sign;
         OP_JZS:  jump_taken = cond_zero || cond_sign;
         default: jump_taken = 1'b0;
      endcase
   end

   // ALU flag write comes first so an accepted LSR/XSR later in the block overrides it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_RUN;
         pc      <= RESET_PC;
         sr      <= 4'b0000;
         epc     <= 20'h00000;
         flush   <= 1'b0;
         trapped <= 1'b0;
      end else begin
         flush <= 1'b0;
         if (alu_flag_valid) begin
            sr[2:0] <= {alu_sign, alu_carry, alu_zero};
         end
         case (state)
            ST_RUN: begin
               if (accept) begin
                  case (op_code)
                     OP_TRAP: begin
                        epc     <= pc_inc;
                        pc      <= TRAP_VECTOR;
                        sr[3]   <= 1'b1;
                        flush   <= 1'b1;
                        trapped <= 1'b1;
                        state   <= ST_TRAP;
                     end
                     OP_JMP, OP_JZ, OP_JS, OP_JZS: begin
                        if (jump_taken) begin
                           pc    <= op_target;
                           flush <= 1'b1;
                           state <= ST_FLUSH;
                        end else begin
                           pc <= pc_inc;
                        end
                     end
                     OP_LSR: begin
                        sr[2:0] <= op_sr_imm;
                        pc      <= pc_inc;
                     end
                     OP_XSR: begin
                        sr[2:0] <= sr[2:0] ^ op_sr_imm;
                        pc      <= pc_inc;
                     end
                     default: pc <= pc_inc;
                  endcase
               end
            end
            ST_FLUSH: state <= ST_RUN;
            ST_TRAP: begin
               if (trap_clear) begin
                  pc      <= epc;
                  sr[3]   <= 1'b0;
                  flush   <= 1'b1;
                  trapped <= 1'b0;
                  state   <= ST_FLUSH;
               end
            end
            default: state <= ST_RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_flow_ctrl_unit.sv
// tb_flow_ctrl_unit: directed scenarios plus randomized traffic against a behavioural model.
module tb_flow_ctrl_unit;

   localparam logic [19:0] RESET_PC    = 20'h00000;
   localparam logic [19:0] TRAP_VECTOR = 20'hFFF00;
   localparam int M_RUN = 0, M_FLUSH = 1, M_TRAP = 2;
   localparam int PC_MOD = 1 << 20;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        op_valid = 1'b0;
   logic        op_ready;
   logic [2:0]  op_code = 3'd1;
   logic [19:0] op_target = 20'h0;
   logic [2:0]  op_sr_imm = 3'd0;
   logic        alu_flag_valid = 1'b0;
   logic        alu_zero = 1'b0, alu_carry = 1'b0, alu_sign = 1'b0;
   logic        trap_clear = 1'b0;
   logic [19:0] pc;
   logic [3:0]  sr;
   logic [19:0] epc;
   logic        flush;
   logic        trapped;
   logic [1:0]  dbg_state;

   int          n_checks = 0;
   int          n_fail = 0;

   // behavioural model state
   int          m_pc = 0;
   int          m_epc = 0;
   bit [3:0]    m_sr = 4'b0;
   bit          m_flush = 1'b0;
   int          m_mode = M_RUN;
   logic [45:0] exp_q[$];

   flow_ctrl_unit #(.RESET_PC(RESET_PC), .TRAP_VECTOR(TRAP_VECTOR)) dut (
      .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
      .op_code(op_code), .op_target(op_target), .op_sr_imm(op_sr_imm),
      .alu_flag_valid(alu_flag_valid), .alu_zero(alu_zero), .alu_carry(alu_carry),
      .alu_sign(alu_sign), .trap_clear(trap_clear), .pc(pc), .sr(sr), .epc(epc),
      .flush(flush), .trapped(trapped), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic model_step();
      int nxt_pc, mode;
      bit [2:0] flags;
      bit tbit, fl, z, s, take;
      if (rst) begin
         m_pc = int'(RESET_PC); m_epc = 0; m_sr = 4'b0; m_flush = 1'b0; m_mode = M_RUN;
         return;
      end
      nxt_pc = m_pc; mode = m_mode; flags = m_sr[2:0]; tbit = m_sr[3]; fl = 1'b0;
      if (alu_flag_valid) flags = {alu_sign, alu_carry, alu_zero};
      if (m_mode == M_RUN && op_valid) begin
         z = m_sr[0]; s = m_sr[2];
`ifdef FLOW_FLAG_BYPASS_EN
         if (alu_flag_valid) begin z = alu_zero; s = alu_sign; end
`endif
         case (op_code)
            3'd0: begin
               m_epc = (m_pc + 1) % PC_MOD; nxt_pc = int'(TRAP_VECTOR);
               tbit = 1'b1; fl = 1'b1; mode = M_TRAP;
            end
            3'd2, 3'd3, 3'd4, 3'd5: begin
               take = (op_code == 3'd2) || (op_code == 3'd3 && z) ||
                      (op_code == 3'd4 && s) || (op_code == 3'd5 && (z || s));
               if (take) begin nxt_pc = int'(op_target); fl = 1'b1; mode = M_FLUSH; end
               else nxt_pc = (m_pc + 1) % PC_MOD;
            end
            default: begin
               nxt_pc = (m_pc + 1) % PC_MOD;
               if (op_code == 3'd6) flags = op_sr_imm;
               if (op_code == 3'd7) flags = m_sr[2:0] ^ op_sr_imm;
            end
         endcase
      end else if (m_mode == M_FLUSH) begin
         mode = M_RUN;
      end else if (m_mode == M_TRAP && trap_clear) begin
         nxt_pc = m_epc; tbit = 1'b0; fl = 1'b1; mode = M_FLUSH;
      end
      m_pc = nxt_pc; m_sr = {tbit, flags}; m_flush = fl; m_mode = mode;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic set_op(input bit v, input logic [2:0] code, input logic [19:0] tgt,
                         input logic [2:0] imm);
      op_valid = v; op_code = code; op_target = tgt; op_sr_imm = imm;
   endtask

   task automatic set_flags(input bit fv, input logic [2:0] scz);
      alu_flag_valid = fv; {alu_sign, alu_carry, alu_zero} = scz;
   endtask

   task automatic test_reset();
      rst = 1'b1; set_op(1'b1, 3'd2, 20'h12345, 3'd0);
      tick(); tick();
      n_checks++;
      if (pc !== RESET_PC || sr !== 4'b0 || epc !== 20'h0 || flush !== 1'b0 ||
          trapped !== 1'b0 || op_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset: pc=%h sr=%b epc=%h flush=%b trapped=%b ready=%b, want %h 0000 0 0 0 0",
                  pc, sr, epc, flush, trapped, op_ready, RESET_PC);
      end
      rst = 1'b0; set_op(1'b0, 3'd1, 20'h0, 3'd0);
      #1;
      n_checks++;
      if (op_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_release_ready: got %b want 1", op_ready);
      end
   endtask

   task automatic test_nop();
      set_op(1'b1, 3'd1, 20'h0, 3'd0);
      for (int i = 1; i <= 3; i++) begin
         tick();
         n_checks++;
         if (pc !== 20'(i) || flush !== 1'b0 || op_ready !== 1'b1 || sr !== 4'b0) begin
            n_fail++;
            $display("FAIL nop[%0d]: pc=%h flush=%b ready=%b sr=%b, want pc=%h flush=0 ready=1 sr=0000",
                     i, pc, flush, op_ready, sr, 20'(i));
         end
      end
      set_op(1'b0, 3'd1, 20'h0, 3'd0);
   endtask

   task automatic test_jz();
      set_flags(1'b1, 3'b001);
      tick();
      set_flags(1'b0, 3'b000); set_op(1'b1, 3'd3, 20'h00400, 3'd0);
      tick();
      n_checks++;
      if (pc !== 20'h00400 || flush !== 1'b1 || op_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL jz_taken: pc=%h flush=%b ready=%b, want 00400 1 0", pc, flush, op_ready);
      end
      set_op(1'b0, 3'd1, 20'h0, 3'd0);
      tick();
      n_checks++;
      if (pc !== 20'h00400 || flush !== 1'b0 || op_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL jz_after_flush: pc=%h flush=%b ready=%b, want 00400 0 1", pc, flush, op_ready);
      end
      set_flags(1'b1, 3'b000);
      tick();
      set_flags(1'b0, 3'b000); set_op(1'b1, 3'd3, 20'h00800, 3'd0);
      tick();
      n_checks++;
      if (pc !== 20'h00401 || flush !== 1'b0 || op_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL jz_not_taken: pc=%h flush=%b ready=%b, want 00401 0 1", pc, flush, op_ready);
      end
      set_op(1'b0, 3'd1, 20'h0, 3'd0);
   endtask

   task automatic test_bypass();
      logic [19:0] want_pc;
      logic        want_flush;
`ifdef FLOW_FLAG_BYPASS_EN
      want_pc = 20'h00080; want_flush = 1'b1;
`else
      want_pc = 20'h00402; want_flush = 1'b0;
`endif
      set_flags(1'b1, 3'b100); set_op(1'b1, 3'd4, 20'h00080, 3'd0);
      tick();
      n_checks++;
      if (pc !== want_pc || flush !== want_flush || sr !== 4'b0100) begin
         n_fail++;
         $display("FAIL js_same_cycle_flag: pc=%h flush=%b sr=%b, want %h %b 0100",
                  pc, flush, sr, want_pc, want_flush);
      end
      set_flags(1'b0, 3'b000); set_op(1'b0, 3'd1, 20'h0, 3'd0);
      tick();
      n_checks++;
      if (op_ready !== 1'b1 || flush !== 1'b0) begin
         n_fail++; $display("FAIL js_settle: ready=%b flush=%b, want 1 0", op_ready, flush);
      end
   endtask

   task automatic test_trap();
      set_op(1'b1, 3'd2, 20'h00010, 3'd0);
      tick();
      set_op(1'b0, 3'd1, 20'h0, 3'd0);
      tick();
      set_op(1'b1, 3'd0, 20'h0, 3'd0);
      tick();
      n_checks++;
      if (pc !== TRAP_VECTOR || epc !== 20'h00011 || sr[3] !== 1'b1 || trapped !== 1'b1 ||
          flush !== 1'b1 || op_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL trap_entry: pc=%h epc=%h sr=%b trapped=%b flush=%b ready=%b, want fff00 00011 1xxx 1 1 0",
                  pc, epc, sr, trapped, flush, op_ready);
      end
      set_op(1'b1, 3'd2, 20'h00777, 3'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if (pc !== TRAP_VECTOR || trapped !== 1'b1 || flush !== 1'b0 || op_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL trap_hold[%0d]: pc=%h trapped=%b flush=%b ready=%b, want fff00 1 0 0",
                     i, pc, trapped, flush, op_ready);
         end
      end
      set_op(1'b0, 3'd1, 20'h0, 3'd0); trap_clear = 1'b1;
      tick();
      trap_clear = 1'b0;
      n_checks++;
      if (pc !== 20'h00011 || sr[3] !== 1'b0 || trapped !== 1'b0 || flush !== 1'b1 ||
          op_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL trap_clear: pc=%h sr=%b trapped=%b flush=%b ready=%b, want 00011 0xxx 0 1 0",
                  pc, sr, trapped, flush, op_ready);
      end
      tick();
      n_checks++;
      if (pc !== 20'h00011 || flush !== 1'b0 || op_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL trap_resume: pc=%h flush=%b ready=%b, want 00011 0 1", pc, flush, op_ready);
      end
   endtask

   task automatic test_sr();
      set_op(1'b1, 3'd6, 20'h0, 3'b101);
      tick();
      n_checks++;
      if (sr !== 4'b0101 || pc !== 20'h00012) begin
         n_fail++; $display("FAIL lsr_101: sr=%b pc=%h, want 0101 00012", sr, pc);
      end
      set_op(1'b1, 3'd7, 20'h0, 3'b011); set_flags(1'b1, 3'b000);
      tick();
      set_flags(1'b0, 3'b000);
      n_checks++;
      if (sr !== 4'b0110 || pc !== 20'h00013) begin
         n_fail++; $display("FAIL xsr_collision: sr=%b pc=%h, want 0110 00013", sr, pc);
      end
      set_op(1'b1, 3'd6, 20'h0, 3'b111);
      tick();
      n_checks++;
      if (sr !== 4'b0111 || pc !== 20'h00014) begin
         n_fail++; $display("FAIL lsr_111: sr=%b pc=%h, want 0111 00014", sr, pc);
      end
      set_op(1'b0, 3'd1, 20'h0, 3'd0);
   endtask

   task automatic test_wrap();
      set_op(1'b1, 3'd2, 20'hFFFFF, 3'd0);
      tick();
      set_op(1'b0, 3'd1, 20'h0, 3'd0);
      tick();
      set_op(1'b1, 3'd1, 20'h0, 3'd0);
      tick();
      n_checks++;
      if (pc !== 20'h00000 || flush !== 1'b0) begin
         n_fail++; $display("FAIL pc_wrap: pc=%h flush=%b, want 00000 0", pc, flush);
      end
      set_op(1'b0, 3'd1, 20'h0, 3'd0);
   endtask

   task automatic test_reset_in_flush();
      set_op(1'b1, 3'd2, 20'h00123, 3'd0);
      tick();
      set_op(1'b0, 3'd1, 20'h0, 3'd0); rst = 1'b1;
      n_checks++;
      if (flush !== 1'b1) begin
         n_fail++; $display("FAIL pre_reset_flush: flush=%b want 1", flush);
      end
      tick();
      n_checks++;
      if (pc !== RESET_PC || flush !== 1'b0 || trapped !== 1'b0 || sr !== 4'b0 || op_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_in_flush: pc=%h flush=%b trapped=%b sr=%b ready=%b, want %h 0 0 0000 0",
                  pc, flush, trapped, sr, op_ready, RESET_PC);
      end
      rst = 1'b0;
      #1;
      n_checks++;
      if (op_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_in_flush_ready: got %b want 1", op_ready);
      end
   endtask

   task automatic test_random();
      logic [45:0] obs, exp_v;
      bit          exp_ready;
      for (int i = 0; i < 600; i++) begin
         rst = ($urandom_range(0, 63) == 0);
         set_op($urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)),
                20'($urandom_range(0, PC_MOD - 1)), 3'($urandom_range(0, 7)));
         set_flags($urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)));
         trap_clear = ($urandom_range(0, 3) == 0);
         tick();
         exp_q.push_back({m_flush, (m_mode == M_TRAP), m_sr, 20'(m_epc), 20'(m_pc)});
         exp_ready = (m_mode == M_RUN) && !rst;
         obs = {flush, trapped, sr, epc, pc};
         exp_v = exp_q.pop_front();
         n_checks++;
         if (obs !== exp_v || op_ready !== exp_ready) begin
            n_fail++;
            $display("FAIL random[%0d]: {flush,trapped,sr,epc,pc}=%h ready=%b, want %h ready=%b",
                     i, obs, op_ready, exp_v, exp_ready);
         end
      end
      rst = 1'b0; trap_clear = 1'b0;
      set_op(1'b0, 3'd1, 20'h0, 3'd0); set_flags(1'b0, 3'b000);
   endtask

   initial begin
      test_reset();
      test_nop();
      test_jz();
      test_bypass();
      test_trap();
      test_sr();
      test_wrap();
      test_reset_in_flush();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
